// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings and FSM state type shared by the data memory files
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;
endpackage

// File: rtl/dmem_align.sv
// dmem_align: big-endian lane steering, load extension and access fault detection
module dmem_align
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 256
) (
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic        fault,
  output logic [3:0]  wbe,
  output logic [31:0] wword,
  output logic [31:0] ld_data
);
  logic [2:0] nbytes;
  logic       misal;
  logic       oob;
  logic       sx;
  assign nbytes  = size == SZ_BYTE ? 3'd1 : size == SZ_HALF ? 3'd2 : 3'd4;
  assign misal   = size == SZ_ILL || (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00);
  assign oob     = ({1'b0, addr} + {30'b0, nbytes}) > 33'(DEPTH_BYTES);
  assign fault   = misal | oob;
  assign sx      = sign_ext & rword[31];
  // rword and wword hold the byte at addr in their top byte; wbe[3] is that byte
  assign wbe     = fault ? 4'b0000 : size == SZ_BYTE ? 4'b1000 : size == SZ_HALF ? 4'b1100 : 4'b1111;
  assign wword   = size == SZ_BYTE ? {wdata[7:0], 24'b0} : size == SZ_HALF ? {wdata[15:0], 16'b0} : wdata;
  assign ld_data = size == SZ_BYTE ? {{24{sx}}, rword[31:24]} :
                   size == SZ_HALF ? {{16{sx}}, rword[31:16]} : rword;
endmodule

// File: rtl/data_mem_be.sv
// data_mem_be: byte-addressed big-endian data memory with 1-cycle loads and fault counting
module data_mem_be
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 req,
  input  logic                 we,
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic                 ready,
  output logic                 rvalid,
  output logic [31:0]          rdata,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  localparam int AW = $clog2(DEPTH_BYTES);
  state_t         state;
  logic [7:0]     mem [DEPTH_BYTES];
  logic [AW-1:0]  idx;
  logic [31:0]    rword;
  logic [31:0]    wword;
  logic [31:0]    ld_data;
  logic [31:0]    rdata_q;
  logic [3:0]     wbe;
  logic           fault;
  logic           acc;
  assign idx    = addr[AW-1:0];
  assign rword  = {mem[idx], mem[idx + AW'(1)], mem[idx + AW'(2)], mem[idx + AW'(3)]};
  assign ready  = state == IDLE;
  assign rvalid = state == RESP;
  assign acc    = req & ready;
  assign rdata  = rdata_q;
  dmem_align #(.DEPTH_BYTES(DEPTH_BYTES)) u_align (
    .size(size),
    .sign_ext(sign_ext),
    .addr(addr),
    .wdata(wdata),
    .rword(rword),
    .fault(fault),
    .wbe(wbe),
    .wword(wword),
    .ld_data(ld_data)
  );
  // FSM, response registers and saturating fault counter; rdata_q clears itself outside RESP
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      err     <= 1'b0;
      rdata_q <= '0;
      err_cnt <= '0;
    end else begin
      state   <= (acc && !we) ? RESP : IDLE;
      err     <= acc & fault;
      rdata_q <= (acc && !we && !fault) ? ld_data : '0;
      if (acc && fault && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end
  end
  // Storage is not reset; faulted stores arrive with wbe cleared
  always_ff @(posedge CLK) begin
    if (acc && we)
      for (int k = 0; k < 4; k++)
        if (wbe[3-k]) mem[idx + AW'(k)] <= wword[31-8*k -: 8];
  end
endmodule
